// File: rtl/dsram_responder.sv
// dsram_responder: data-SRAM slave with byte-lane writes, configurable read latency and a stall request while a read is in flight.
// Optional feature macro DSRAM_RANGE_CHECK_EN: adds addr_err, drops out-of-range writes and returns zero for out-of-range reads.
module dsram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        busy
`ifdef DSRAM_RANGE_CHECK_EN
  ,
  output logic        addr_err
`endif
);
  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
    $error("dsram_responder: RD_LATENCY must be in 1..7");
  end
  localparam bit MULTI = RD_LATENCY > 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rd_buf, rd_word;
  logic [ADDR_WIDTH-1:0] idx;
  logic oor, rd_req, wr_req, ld;
  logic unused_addr;
  assign idx = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2]};
`ifdef DSRAM_RANGE_CHECK_EN
  assign oor = |req_addr[31:ADDR_WIDTH+2];
`else
  assign oor = 1'b0;
`endif
  assign rd_req = state == IDLE && req_en && req_wen == 4'h0;
  assign wr_req = state == IDLE && req_en && req_wen != 4'h0;
  assign rd_word = oor ? 32'h0 : mem[idx];
  assign ld = MULTI ? state == WAIT && cnt == 3'd1 : rd_req;
  assign stallreq = MULTI && (rd_req || (state == WAIT && cnt > 3'd1));
  assign busy = state != IDLE;
  // next-state: a multi-cycle read parks in WAIT while the counter runs down
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE && rd_req && MULTI) begin
      state_nx = WAIT;
      cnt_nx = 3'(RD_LATENCY - 1);
    end else if (state == WAIT) begin
      cnt_nx = cnt - 3'd1;
      state_nx = cnt == 3'd1 ? IDLE : WAIT;
    end
  end
  // state, counter and load-data registers; reset discards any pending read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= 3'd0;
      rd_buf <= 32'h0;
      rdata <= 32'h0;
      rdata_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      rdata_valid <= ld;
      if (rd_req) rd_buf <= rd_word;
      if (ld) rdata <= MULTI ? rd_buf : rd_word;
    end
  end
`ifdef DSRAM_RANGE_CHECK_EN
  // one-cycle error pulse after any accepted out-of-range request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) addr_err <= 1'b0;
    else addr_err <= (rd_req || wr_req) && oor;
  end
`endif
  // byte-lane write port; storage is never cleared
  always_ff @(posedge clk) begin
    if (wr_req && !oor && resetn)
      for (int i = 0; i < 4; i++)
        if (req_wen[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dsram_responder.sv
// tb_dsram_responder: randomized bench for dsram_responder at latencies 1 and 3 against a word-array reference model.
module tb_dsram_responder;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en [2];
  logic [3:0] wen [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rd [2];
  logic vld [2];
  logic stl [2];
  logic bsy [2];
`ifdef DSRAM_RANGE_CHECK_EN
  logic aerr [2];
`endif
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  dsram_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .req_en(en[0]), .req_wen(wen[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .rdata(rd[0]), .rdata_valid(vld[0]), .stallreq(stl[0]), .busy(bsy[0])
`ifdef DSRAM_RANGE_CHECK_EN
    , .addr_err(aerr[0])
`endif
  );

  dsram_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .resetn(resetn), .req_en(en[1]), .req_wen(wen[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .rdata(rd[1]), .rdata_valid(vld[1]), .stallreq(stl[1]), .busy(bsy[1])
`ifdef DSRAM_RANGE_CHECK_EN
    , .addr_err(aerr[1])
`endif
  );

  function automatic bit oor(input logic [31:0] a);
    bit chk = 1'b0;
`ifdef DSRAM_RANGE_CHECK_EN
    chk = 1'b1;
`endif
    return chk && (a >> (AW + 2)) != 0;
  endfunction

  function automatic int key(input int k, input logic [31:0] a);
    return k * (1 << AW) + int'((a >> 2) & ((1 << AW) - 1));
  endfunction

  function automatic logic [31:0] exp_read(input int k, input logic [31:0] a);
    if (oor(a) || !model.exists(key(k, a))) return 32'h0;
    return model[key(k, a)];
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int kk;
    logic [31:0] w;
    if (oor(a)) return;
    kk = key(k, a);
    w = model.exists(kk) ? model[kk] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    model[kk] = w;
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    en[k] = 1'b1; wen[k] = be; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    n_tests += 2;
    if (stl[k] !== 1'b0) begin n_fail++; $display("FAIL wr_stall k=%0d got %b exp 0", k, stl[k]); end
    if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL wr_busy k=%0d got %b exp 0", k, bsy[k]); end
    @(posedge clk);
    model_write(k, a, be, d);
    #1;
    en[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [31:0] a);
    int l = k ? 3 : 1;
    logic [31:0] e = exp_read(k, a);
    en[k] = 1'b1; wen[k] = 4'h0; addr[k] = a; wdata[k] = $urandom;
    for (int c = 0; c <= l; c++) begin
      if (c == l) en[k] = 1'b0;
      @(negedge clk);
      n_tests += 3;
      if (stl[k] !== (l > 1 && c < l - 1)) begin n_fail++; $display("FAIL rd_stall k=%0d c=%0d got %b exp %b", k, c, stl[k], l > 1 && c < l - 1); end
      if (vld[k] !== (c == l)) begin n_fail++; $display("FAIL rd_valid k=%0d c=%0d got %b exp %b", k, c, vld[k], c == l); end
      if (bsy[k] !== (c > 0 && c < l)) begin n_fail++; $display("FAIL rd_busy k=%0d c=%0d got %b exp %b", k, c, bsy[k], c > 0 && c < l); end
      if (c == l) begin
        n_tests++;
        if (rd[k] !== e) begin n_fail++; $display("FAIL rd_data k=%0d addr=%h got %h exp %h", k, a, rd[k], e); end
      end
`ifdef DSRAM_RANGE_CHECK_EN
      if (c == 1) begin
        n_tests++;
        if (aerr[k] !== oor(a)) begin n_fail++; $display("FAIL rd_addr_err k=%0d addr=%h got %b exp %b", k, a, aerr[k], oor(a)); end
      end
`endif
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests += 4;
      if (rd[k] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata k=%0d got %h exp 0", k, rd[k]); end
      if (vld[k] !== 1'b0) begin n_fail++; $display("FAIL rst_valid k=%0d got %b exp 0", k, vld[k]); end
      if (stl[k] !== 1'b0) begin n_fail++; $display("FAIL rst_stall k=%0d got %b exp 0", k, stl[k]); end
      if (bsy[k] !== 1'b0) begin n_fail++; $display("FAIL rst_busy k=%0d got %b exp 0", k, bsy[k]); end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_full_write_read;
    do_write(0, 32'h10, 4'hF, 32'hDEADBEEF);
    do_read(0, 32'h10);
    n_tests++;
    if (rd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_wr_rd got %h exp deadbeef", rd[0]); end
  endtask

  task automatic test_byte_lanes;
    do_write(0, 32'h20, 4'hF, 32'h11223344);
    do_write(0, 32'h22, 4'b0101, 32'hAABBCCDD);
    do_read(0, 32'h20);
    n_tests++;
    if (rd[0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes got %h exp 11bb33dd", rd[0]); end
  endtask

  task automatic test_latency3;
    logic [31:0] d = $urandom;
    do_write(1, 32'h10, 4'hF, d);
    do_read(1, 32'h10);
    @(negedge clk);
    n_tests += 2;
    if (vld[1] !== 1'b0) begin n_fail++; $display("FAIL lat3_extra_valid got %b exp 0", vld[1]); end
    if (rd[1] !== d) begin n_fail++; $display("FAIL lat3_hold got %h exp %h", rd[1], d); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait;
    do_write(1, 32'h40, 4'hF, 32'hCAFEF00D);
    do_read(1, 32'h40);
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h40;
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    resetn = 1'b0;
    #1;
    n_tests += 4;
    if (rd[1] !== 32'h0) begin n_fail++; $display("FAIL midwait_rdata got %h exp 0", rd[1]); end
    if (vld[1] !== 1'b0) begin n_fail++; $display("FAIL midwait_valid got %b exp 0", vld[1]); end
    if (stl[1] !== 1'b0) begin n_fail++; $display("FAIL midwait_stall got %b exp 0", stl[1]); end
    if (bsy[1] !== 1'b0) begin n_fail++; $display("FAIL midwait_busy got %b exp 0", bsy[1]); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    do_read(1, 32'h40);
  endtask

  task automatic test_alias;
`ifndef DSRAM_RANGE_CHECK_EN
    do_write(0, 32'h1000, 4'hF, 32'h5A5A5A5A);
    do_read(0, 32'h0);
    n_tests++;
    if (rd[0] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL alias got %h exp 5a5a5a5a", rd[0]); end
`endif
  endtask

  task automatic test_range;
`ifdef DSRAM_RANGE_CHECK_EN
    do_write(0, 32'h0, 4'hF, 32'h01020304);
    do_write(0, 32'h1000, 4'hF, 32'h12345678);
    @(negedge clk);
    n_tests++;
    if (aerr[0] !== 1'b1) begin n_fail++; $display("FAIL range_wr_err got %b exp 1", aerr[0]); end
    @(posedge clk);
    #1;
    do_read(0, 32'h0);
    n_tests++;
    if (rd[0] !== 32'h01020304) begin n_fail++; $display("FAIL range_word0 got %h exp 01020304", rd[0]); end
    do_read(0, 32'h1000);
    n_tests++;
    if (rd[0] !== 32'h0) begin n_fail++; $display("FAIL range_rd_zero got %h exp 0", rd[0]); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] q [$];
    for (int i = 0; i < 4; i++) do_write(0, 32'h100 + 32'(4 * i), 4'hF, $urandom);
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) begin en[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h100 + 32'(4 * c); end
      else en[0] = 1'b0;
      @(negedge clk);
      n_tests += 2;
      if (stl[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_stall c=%0d got %b exp 0", c, stl[0]); end
      if (vld[0] !== (c > 0)) begin n_fail++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, vld[0], c > 0); end
      if (c > 0) begin
        logic [31:0] e = q.pop_front();
        n_tests++;
        if (rd[0] !== e) begin n_fail++; $display("FAIL b2b_data c=%0d got %h exp %h", c, rd[0], e); end
      end
      if (c < 4) q.push_back(exp_read(0, addr[0]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 8; w++) do_write(k, 32'h200 + 32'(4 * w), 4'hF, $urandom);
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a = 32'h200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a[31:AW+2] = 20'($urandom);
        if ($urandom_range(0, 1) == 1) do_write(k, a, 4'($urandom_range(1, 15)), $urandom);
        else do_read(k, a);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; wen[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_full_write_read;
    test_byte_lanes;
    test_latency3;
    test_reset_mid_wait;
    test_alias;
    test_range;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
